// File: rtl/costas_loop_ctrl.sv
// Costas carrier-recovery loop controller: BPSK phase detector, PI loop filter and
// centre-frequency summation producing the NCO phase-increment word, plus lock detect.
module costas_loop_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int PHASE_WIDTH = 32,
  parameter int INT_WIDTH   = 24,
  parameter int LOCK_COUNT  = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  i_sample,
  input  logic [DATA_WIDTH-1:0]  q_sample,
  input  logic                   loop_clr,
  input  logic [PHASE_WIDTH-1:0] fc_word,
  input  logic [4:0]             kp_shift,
  input  logic [4:0]             ki_shift,
  output logic [PHASE_WIDTH-1:0] phi_inc_o,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  err_o,
  output logic                   lock
);

  localparam int CW = $clog2(LOCK_COUNT + 1);

  localparam logic signed [DATA_WIDTH-1:0] S_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] S_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [INT_WIDTH-1:0]  INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic signed [INT_WIDTH-1:0]  INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};

  // Negation that maps the most negative code to the most positive one.
  function automatic logic signed [DATA_WIDTH-1:0] sat_neg(input logic signed [DATA_WIDTH-1:0] x);
    return (x == S_MIN) ? S_MAX : -x;
  endfunction

  // Stage 0: captured input sample
  logic                          v0_q;
  logic signed [DATA_WIDTH-1:0]  i_q, q_q;
  // Stage 1: phase error and lock detector
  logic                          v1_q;
  logic signed [DATA_WIDTH-1:0]  err_q, err_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          lock_q;
  // Stage 2: loop filter
  logic                          v2_q;
  logic signed [INT_WIDTH-1:0]   prop_q, prop_d;
  logic signed [INT_WIDTH-1:0]   integ_q, integ_d;
  // Stage 3: NCO word
  logic                          out_valid_q;
  logic [PHASE_WIDTH-1:0]        phi_inc_q, phi_inc_d;

  logic signed [DATA_WIDTH-1:0]  abs_i, abs_q, prop_s, inc_s;
  logic signed [INT_WIDTH:0]     integ_wide, pi_sum;
  logic signed [PHASE_WIDTH+1:0] sum;

  // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    err_d = i_q[DATA_WIDTH-1] ? sat_neg(q_q) : q_q;
    abs_i = i_q[DATA_WIDTH-1] ? sat_neg(i_q) : i_q;
    abs_q = q_q[DATA_WIDTH-1] ? sat_neg(q_q) : q_q;

    cnt_d = '0;
    if (abs_i > abs_q) begin
      cnt_d = (cnt_q == CW'(LOCK_COUNT)) ? cnt_q : cnt_q + 1'b1;
    end

    // Arithmetic shifts past the sample width collapse to 0 or -1 by sign fill.
    prop_s     = err_q >>> kp_shift;
    inc_s      = err_q >>> ki_shift;
    prop_d     = INT_WIDTH'(prop_s);
    integ_wide = (INT_WIDTH+1)'(integ_q) + (INT_WIDTH+1)'(inc_s);
    integ_d    = integ_wide[INT_WIDTH-1:0];
    if (integ_wide[INT_WIDTH] != integ_wide[INT_WIDTH-1]) begin
      integ_d = integ_wide[INT_WIDTH] ? INT_MIN : INT_MAX;
    end

    pi_sum    = (INT_WIDTH+1)'(prop_q) + (INT_WIDTH+1)'(integ_q);
    sum       = $signed({2'b00, fc_word}) + (PHASE_WIDTH+2)'(pi_sum);
    phi_inc_d = sum[PHASE_WIDTH-1:0];
    if (sum[PHASE_WIDTH+1]) begin
      phi_inc_d = '0;
    end else if (sum[PHASE_WIDTH]) begin
      phi_inc_d = '1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage sees last cycle's values.
  always_ff @(posedge clk) begin
    if (!reset_n || loop_clr) begin
      v0_q        <= 1'b0;
      i_q         <= '0;
      q_q         <= '0;
      v1_q        <= 1'b0;
      err_q       <= '0;
      cnt_q       <= '0;
      lock_q      <= 1'b0;
      v2_q        <= 1'b0;
      prop_q      <= '0;
      integ_q     <= '0;
      out_valid_q <= 1'b0;
      phi_inc_q   <= fc_word;
    end else begin
      v0_q <= in_valid;
      if (in_valid) begin
        i_q <= i_sample;
        q_q <= q_sample;
      end

      v1_q <= v0_q;
      if (v0_q) begin
        err_q  <= err_d;
        cnt_q  <= cnt_d;
        lock_q <= (cnt_d == CW'(LOCK_COUNT));
      end

      v2_q <= v1_q;
      if (v1_q) begin
        prop_q  <= prop_d;
        integ_q <= integ_d;
      end

      out_valid_q <= v2_q;
      if (v2_q) begin
        phi_inc_q <= phi_inc_d;
      end
    end
  end

  assign phi_inc_o = phi_inc_q;
  assign out_valid = out_valid_q;
  assign err_o     = err_q;
  assign lock      = lock_q;

endmodule

// File: tb/tb_costas_loop_ctrl.sv
// Self-checking bench for costas_loop_ctrl: a reference model pushes expected NCO
// words to a scoreboard at drive time; a negedge monitor pops them on out_valid.
module tb_costas_loop_ctrl;

  localparam int DW = 8;
  localparam int PW = 32;
  localparam int IW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [DW-1:0] i_sample, q_sample;
  logic          loop_clr;
  logic [PW-1:0] fc_word;
  logic [4:0]    kp_shift, ki_shift;
  logic [PW-1:0] phi_inc_o;
  logic          out_valid;
  logic [DW-1:0] err_o;
  logic          lock;

  costas_loop_ctrl #(.DATA_WIDTH(DW), .PHASE_WIDTH(PW), .INT_WIDTH(IW), .LOCK_COUNT(64)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .i_sample(i_sample),
    .q_sample(q_sample), .loop_clr(loop_clr), .fc_word(fc_word), .kp_shift(kp_shift),
    .ki_shift(ki_shift), .phi_inc_o(phi_inc_o), .out_valid(out_valid), .err_o(err_o),
    .lock(lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] phi;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   model_integ = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int m_neg(input int x);
    return (x == -128) ? 127 : -x;
  endfunction

  function automatic int m_err(input int i, input int q);
    return (i < 0) ? m_neg(q) : q;
  endfunction

  // Monitor: every out_valid must match the oldest expectation, at the right cycle.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_out_valid: got phi=%h with no sample pending (cyc %0d)", phi_inc_o, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (phi_inc_o !== e.phi || cyc !== e.cyc) begin
          $display("FAIL scoreboard_phi: got phi=%h at cyc %0d, expected phi=%h at cyc %0d",
                   phi_inc_o, cyc, e.phi, e.cyc);
        end else begin
          pass_cnt++;
        end
      end
    end
  end

  // Drive one sample at a negedge and push its model result.
  task automatic send(input int i, input int q);
    exp_t    e;
    int      err;
    int      prop;
    longint  s;
    @(negedge clk);
    in_valid = 1'b1;
    i_sample = 8'(i);
    q_sample = 8'(q);
    err  = m_err(i, q);
    prop = err >>> kp_shift;
    model_integ = model_integ + (err >>> ki_shift);
    if (model_integ > (1 << (IW-1)) - 1) model_integ = (1 << (IW-1)) - 1;
    if (model_integ < -(1 << (IW-1)))    model_integ = -(1 << (IW-1));
    s = longint'(fc_word) + longint'(prop) + longint'(model_integ);
    if (s < 0) s = 0;
    if (s > 64'h0000_0000_FFFF_FFFF) s = 64'h0000_0000_FFFF_FFFF;
    e.phi = s[PW-1:0];
    e.cyc = cyc + 4;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (sb.size() != 0) $display("FAIL %s_drain: %0d outputs still pending, expected 0", name, sb.size());
    else pass_cnt++;
  endtask

  task automatic do_clear();
    @(negedge clk);
    in_valid = 1'b0;
    loop_clr = 1'b1;
    @(negedge clk);
    loop_clr = 1'b0;
    sb.delete();
    model_integ = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; loop_clr = 1'b0; in_valid = 1'b0;
    i_sample = '0; q_sample = '0;
    fc_word = 32'h0400_0000; kp_shift = 5'd2; ki_shift = 5'd6;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total_cnt += 4;
    if (phi_inc_o !== 32'h0400_0000) $display("FAIL reset_phi: got %h, expected 04000000", phi_inc_o); else pass_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, expected 0", out_valid); else pass_cnt++;
    if (lock !== 1'b0) $display("FAIL reset_lock: got %b, expected 0", lock); else pass_cnt++;
    if (err_o !== 8'h00) $display("FAIL reset_err: got %h, expected 00", err_o); else pass_cnt++;
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_err;
    exp_err = 8'd40;
    send(100, 40);
    idle(2);
    total_cnt++;
    if (err_o !== exp_err) $display("FAIL single_err: got %0d, expected %0d", err_o, exp_err); else pass_cnt++;
    drain("single");
    total_cnt++;
    if (phi_inc_o !== 32'h0400_000A) $display("FAIL single_phi: got %h, expected 0400000A", phi_inc_o); else pass_cnt++;
  endtask

  task automatic test_sign_sat();
    logic [DW-1:0] exp_err;
    logic [PW-1:0] exp_phi;
    exp_err = 8'd127;
    do_clear();
    kp_shift = 5'd0; ki_shift = 5'd0;
    send(-5, -128);
    idle(2);
    total_cnt++;
    if (err_o !== exp_err) $display("FAIL sign_sat_err: got %0d, expected %0d", err_o, exp_err); else pass_cnt++;
    drain("sign_sat_first");
    for (int k = 0; k < 40; k++) send(-5, -128);
    idle(1);
    drain("sign_sat_burst");
    // 41 samples integrated plus one proportional term
    exp_phi = 32'h0400_0000 + 32'(127 * 42);
    total_cnt++;
    if (phi_inc_o !== exp_phi) $display("FAIL sign_sat_ramp: got %h, expected %h", phi_inc_o, exp_phi); else pass_cnt++;
  endtask

  task automatic test_clamp();
    do_clear();
    fc_word = 32'h0000_0010; kp_shift = 5'd0; ki_shift = 5'd31;
    send(-1, 100);
    idle(1);
    drain("clamp_low");
    total_cnt++;
    if (phi_inc_o !== 32'h0000_0000) $display("FAIL clamp_low: got %h, expected 00000000", phi_inc_o); else pass_cnt++;
    do_clear();
    fc_word = 32'hFFFF_FFF0;
    send(1, 100);
    idle(1);
    drain("clamp_high");
    total_cnt++;
    if (phi_inc_o !== 32'hFFFF_FFFF) $display("FAIL clamp_high: got %h, expected FFFFFFFF", phi_inc_o); else pass_cnt++;
  endtask

  task automatic check_lock(input string name, input logic expv);
    total_cnt++;
    if (lock !== expv) $display("FAIL %s: got lock=%b, expected %b", name, lock, expv); else pass_cnt++;
  endtask

  task automatic test_lock();
    do_clear();
    fc_word = 32'h0400_0000; kp_shift = 5'd4; ki_shift = 5'd8;
    for (int k = 0; k < 63; k++) send(100, 10);
    idle(2);
    check_lock("lock_after_63", 1'b0);
    send(100, 10);
    idle(2);
    check_lock("lock_after_64", 1'b1);
    send(10, 100);
    idle(2);
    check_lock("lock_drop", 1'b0);
    for (int k = 0; k < 63; k++) send(-100, 10);
    idle(2);
    check_lock("lock_restart_63", 1'b0);
    send(100, -10);
    idle(2);
    check_lock("lock_restart_64", 1'b1);
    drain("lock");
  endtask

  task automatic test_clear_midflight(input logic use_reset, input string name);
    logic [PW-1:0] new_fc;
    new_fc = use_reset ? 32'h0200_0000 : 32'h0300_0000;
    do_clear();
    fc_word = 32'h0400_0000; kp_shift = 5'd1; ki_shift = 5'd1;
    send(50, 60);
    send(50, 70);
    @(negedge clk);
    in_valid = 1'b1;
    i_sample = 8'd20; q_sample = 8'd90;
    fc_word  = new_fc;
    if (use_reset) reset_n = 1'b0; else loop_clr = 1'b1;
    sb.delete();
    model_integ = 0;
    @(negedge clk);
    in_valid = 1'b0; reset_n = 1'b1; loop_clr = 1'b0;
    total_cnt += 4;
    if (phi_inc_o !== new_fc) $display("FAIL %s_phi: got %h, expected %h", name, phi_inc_o, new_fc); else pass_cnt++;
    if (out_valid !== 1'b0) $display("FAIL %s_out_valid: got %b, expected 0", name, out_valid); else pass_cnt++;
    if (err_o !== 8'h00) $display("FAIL %s_err: got %h, expected 00", name, err_o); else pass_cnt++;
    if (lock !== 1'b0) $display("FAIL %s_lock: got %b, expected 0", name, lock); else pass_cnt++;
    repeat (6) @(negedge clk);
    // A fresh sample exposes any integrator residue from the dropped samples.
    kp_shift = 5'd0; ki_shift = 5'd0;
    send(30, 25);
    idle(1);
    drain(name);
    total_cnt++;
    if (phi_inc_o !== new_fc + 32'd50) $display("FAIL %s_integ: got %h, expected %h", name, phi_inc_o, new_fc + 32'd50);
    else pass_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_sign_sat();
    test_clamp();
    test_lock();
    test_clear_midflight(1'b0, "clr_mid");
    test_clear_midflight(1'b1, "rst_mid");
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
